gshare_predictor: RTL
=====================

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 10, pattern table index width; table depth N = 2^INDEX_BITS.
REQ-002 SHALL have parameter HIST_BITS, default 8, global history length; legal range 1..INDEX_BITS.
REQ-003 SHALL have parameter CTR_BITS, default 2, saturating counter width; legal range 2..4.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port lookup_valid  in  1  a branch prediction is consumed this cycle.
REQ-007 SHALL have port lookup_pc  in  32  PC of the branch being predicted.
REQ-008 SHALL have port predict_taken  out  1  prediction for lookup_pc, combinational.
REQ-009 SHALL have port predict_hist  out  HIST_BITS  GHR value used for this prediction; the pipeline carries it to update.
REQ-010 SHALL have port ready  out  1  table initialised; predictions and updates honoured.
REQ-011 SHALL have port update_en  in  1  resolved branch outcome valid.
REQ-012 SHALL have port update_pc  in  32  PC of the resolved branch.
REQ-013 SHALL have port update_hist  in  HIST_BITS  history snapshot returned with the branch.
REQ-014 SHALL have port update_taken  in  1  actual direction.
REQ-015 SHALL have port update_mispredict  in  1  resolved direction differed from prediction; qualified by update_en.

Function
REQ-016 Lookup index SHALL be lookup_pc[INDEX_BITS+1:2] XOR ghr, with ghr zero-extended at the MSB end to INDEX_BITS.
REQ-017 Update index SHALL be update_pc[INDEX_BITS+1:2] XOR update_hist, with update_hist zero-extended the same way.
REQ-018 predict_taken SHALL equal the counter MSB at the lookup index when ready=1, and 0 when ready=0.
REQ-019 predict_hist SHALL equal the current ghr, i.e. the value before any shift this cycle.
REQ-020 Update with update_taken=1 SHALL increment the counter, saturating at 2^CTR_BITS-1; update_taken=0 SHALL decrement, saturating at 0.
REQ-021 FSM SHALL have states INIT and RUN; ready SHALL be 1 only in RUN.
REQ-022 INIT SHALL write one entry per cycle, entries 0..N-1 in order, with WNT = 2^(CTR_BITS-1)-1, then enter RUN; INIT SHALL last exactly N cycles after reset_n rises.
REQ-023 In INIT, lookups and updates SHALL be ignored and ghr SHALL hold 0.
REQ-024 In RUN, if update_en=1 and update_mispredict=1, ghr SHALL load {update_hist[HIST_BITS-2:0], update_taken}; this recovery has priority over any lookup shift that cycle.
REQ-025 Otherwise in RUN, lookup_valid=1 SHALL shift ghr to {ghr[HIST_BITS-2:0], predict_taken}.
REQ-026 For HIST_BITS=1, the recovery value SHALL be update_taken and the shift value SHALL be predict_taken.
REQ-027 A correct update (update_mispredict=0) SHALL leave ghr untouched and SHALL train the counter only.
REQ-028 When lookup and update hit the same index in the same cycle, the prediction SHALL use the pre-update counter value (read-before-write).
REQ-029 Counter update SHALL be visible to a lookup on the following cycle.

Reset
REQ-030 While reset_n=0: ready=0, predict_taken=0, ghr=0, predict_hist=0, FSM=INIT, init pointer=0.
REQ-031 Asserting reset_n at any point, including mid-INIT or mid-update, SHALL abort the activity and restart a full N-cycle INIT after release.
REQ-032 Table contents SHALL NOT be async-reset; the INIT sweep is the only initialisation.

Verification (INDEX_BITS=4, HIST_BITS=4, CTR_BITS=2)
REQ-033 Release reset_n -> ready=0 for 16 cycles, ready=1 on cycle 16; predict_taken=0 throughout INIT.
REQ-034 Two updates pc=0x40, hist=0, taken, no mispredict -> counter 01->10->11; then lookup pc=0x40 with ghr=0 -> predict_taken=1, ghr unchanged by the updates.
REQ-035 Three further taken updates -> counter stays 11; then one not-taken -> 10 (predict 1); a second not-taken -> 01 (predict 0).
REQ-036 Three lookups predicting 0 -> ghr=0000; then update_mispredict=1, update_hist=0101, update_taken=1, with lookup_valid=1 the same cycle -> ghr=1011 and no shift.
REQ-037 Train pc=0x40 with ghr=0 to 11; set ghr=0001; lookup pc=0x44 -> index 1 XOR 1 = 0, predict_taken=1 (shared entry).
REQ-038 Drop reset_n at INIT cycle 5 -> ready=0 immediately; after release INIT restarts and ready rises 16 cycles later.

Source files
------------

// File: rtl/gshare_predictor.sv
// gshare_predictor: global-history branch direction predictor.
// A pattern history table of CTR_BITS saturating counters is indexed by
// PC[INDEX_BITS+1:2] XOR the global history register (GHR). After reset
// an INIT sweep writes every entry to weakly-not-taken, one per cycle,
// and then the predictor enters RUN.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   lookup_valid, lookup_pc       prediction consumed this cycle / its PC
//   predict_taken                 combinational prediction for lookup_pc
//   predict_hist                  GHR value used for this prediction
//   ready                         table initialised (RUN state)
//   update_en, update_pc,         resolved branch: PC, history snapshot,
//   update_hist, update_taken,    actual direction and mispredict flag
//   update_mispredict
module gshare_predictor #(
    parameter int unsigned INDEX_BITS = 10,
    parameter int unsigned HIST_BITS  = 8,
    parameter int unsigned CTR_BITS   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 lookup_valid,
    input  logic [31:0]          lookup_pc,
    output logic                 predict_taken,
    output logic [HIST_BITS-1:0] predict_hist,
    output logic                 ready,
    input  logic                 update_en,
    input  logic [31:0]          update_pc,
    input  logic [HIST_BITS-1:0] update_hist,
    input  logic                 update_taken,
    input  logic                 update_mispredict
);

    localparam int unsigned N = 1 << INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] PTR_LAST = INDEX_BITS'(N - 1);
    localparam logic [CTR_BITS-1:0]   CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0]   CTR_WNT  = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [INDEX_BITS-1:0] ptr_q, ptr_d;
    logic [HIST_BITS-1:0]  ghr_q, ghr_d;

    logic [CTR_BITS-1:0]   pht_q [N];

    logic [INDEX_BITS-1:0] lk_idx, upd_idx, wr_idx;
    logic [CTR_BITS-1:0]   upd_ctr, ctr_next, wr_val;
    logic                  wr_en;
    logic [HIST_BITS-1:0]  ghr_shift, ghr_recover;

    // Only PC[INDEX_BITS+1:2] participates in indexing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0],
                              update_pc[31:INDEX_BITS+2], update_pc[1:0]};

    // Index hashing; history is zero-extended at the MSB end.
    assign lk_idx  = lookup_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
    assign upd_idx = update_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(update_hist);

    assign ready         = (state_q == ST_RUN);
    assign predict_taken = ready & pht_q[lk_idx][CTR_BITS-1];
    assign predict_hist  = ghr_q;

    // Truncating the concatenation keeps the low HIST_BITS bits, which
    // also covers HIST_BITS == 1 (result is just the new bit).
    assign ghr_shift   = HIST_BITS'({ghr_q, predict_taken});
    assign ghr_recover = HIST_BITS'({update_hist, update_taken});

    // Saturating counter step for the resolved branch.
    always_comb begin
        upd_ctr  = pht_q[upd_idx];
        ctr_next = upd_ctr;
        if (update_taken) begin
            if (upd_ctr != CTR_MAX) ctr_next = upd_ctr + CTR_BITS'(1);
        end else begin
            if (upd_ctr != '0) ctr_next = upd_ctr - CTR_BITS'(1);
        end
    end

    // Next-state, table write port and GHR control.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ghr_d   = ghr_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        wr_val  = CTR_WNT;
        case (state_q)
            ST_INIT: begin
                wr_en = 1'b1;
                ghr_d = '0;
                ptr_d = ptr_q + INDEX_BITS'(1);
                if (ptr_q == PTR_LAST) begin
                    ptr_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (update_en) begin
                    wr_en  = 1'b1;
                    wr_idx = upd_idx;
                    wr_val = ctr_next;
                end
                // Mispredict recovery wins over a same-cycle lookup shift.
                if (update_en && update_mispredict) begin
                    ghr_d = ghr_recover;
                end else if (lookup_valid) begin
                    ghr_d = ghr_shift;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Control state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ghr_q   <= ghr_d;
        end
    end

    // Pattern table: no reset; the INIT sweep initialises it.
    always_ff @(posedge clk) begin
        if (wr_en) pht_q[wr_idx] <= wr_val;
    end

endmodule
